// File: rtl/align_accumulate.sv
// Aligns nine (exponent, mantissa) product terms to a shared max exponent and sums them serially.
// Latency: acceptance at edge N, result valid after edge N+9 (one term per cycle).
// Backpressure: single-set occupancy; in_ready only in IDLE, result held in DONE until out_ready.
module align_accumulate #(
  parameter int MAN_W = 12,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       exp_0,
  input  logic [4:0]       exp_1,
  input  logic [4:0]       exp_2,
  input  logic [4:0]       exp_3,
  input  logic [4:0]       exp_4,
  input  logic [4:0]       exp_5,
  input  logic [4:0]       exp_6,
  input  logic [4:0]       exp_7,
  input  logic [4:0]       exp_8,
  input  logic [MAN_W-1:0] man_0,
  input  logic [MAN_W-1:0] man_1,
  input  logic [MAN_W-1:0] man_2,
  input  logic [MAN_W-1:0] man_3,
  input  logic [MAN_W-1:0] man_4,
  input  logic [MAN_W-1:0] man_5,
  input  logic [MAN_W-1:0] man_6,
  input  logic [MAN_W-1:0] man_7,
  input  logic [MAN_W-1:0] man_8,
  input  logic [4:0]       exp_max,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum,
  output logic [4:0]       sum_exp
);

  localparam int N_TERMS = 9;
  localparam logic [3:0] LAST_TERM = 4'd8;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [4:0]        emax_q, emax_d;
  logic [4:0]        exp_q [N_TERMS];
  logic [4:0]        exp_d [N_TERMS];
  logic [MAN_W-1:0]  man_q [N_TERMS];
  logic [MAN_W-1:0]  man_d [N_TERMS];

  logic [4:0]        exp_in [N_TERMS];
  logic [MAN_W-1:0]  man_in [N_TERMS];

  logic [4:0]               sel_exp;
  logic [MAN_W-1:0]         sel_man;
  logic [4:0]               shamt;
  logic signed [ACC_W-1:0]  ext;
  logic signed [ACC_W-1:0]  term;

  assign exp_in = '{exp_0, exp_1, exp_2, exp_3, exp_4, exp_5, exp_6, exp_7, exp_8};
  assign man_in = '{man_0, man_1, man_2, man_3, man_4, man_5, man_6, man_7, man_8};

  // Align the currently selected term: shift right by the exponent gap. A term whose
  // exponent exceeds the reported max is an upstream error and is taken unshifted; a gap
  // of MAN_W or more shifts out every significant bit, so it contributes exactly zero
  // rather than the -1 an arithmetic shift of a negative value would leave.
  always_comb begin
    sel_exp = exp_q[cnt_q];
    sel_man = man_q[cnt_q];
    shamt   = (sel_exp > emax_q) ? 5'd0 : (emax_q - sel_exp);
    ext     = {{(ACC_W-MAN_W){sel_man[MAN_W-1]}}, sel_man};
    if ({27'd0, shamt} >= 32'(MAN_W)) begin
      term = '0;
    end else begin
      term = ext >>> shamt;
    end
  end

  // Next-state logic: capture in IDLE, add one term per cycle in ACCUM, hold in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    emax_d  = emax_q;
    exp_d   = exp_q;
    man_d   = man_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          exp_d   = exp_in;
          man_d   = man_in;
          emax_d  = exp_max;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        // Plain modulo-2^ACC_W add; wraps only if the width rule is broken.
        acc_d = acc_q + term;
        if (cnt_q == LAST_TERM) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any set in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      emax_q  <= '0;
      for (int i = 0; i < N_TERMS; i++) begin
        exp_q[i] <= '0;
        man_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      emax_q  <= emax_d;
      exp_q   <= exp_d;
      man_q   <= man_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = acc_q;
  assign sum_exp   = emax_q;

endmodule
